// File: rtl/gb_joypad.sv
// Game Boy P1/JOYP register (0xFF00): debounces SNES buttons, maps them onto the 2x4 select matrix.
// Optional JOYPAD_SOCD_CLEAN_EN cancels opposing directions after debounce.
module gb_joypad #(
  parameter int DEBOUNCE_W = 12
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [15:0] snes_buttons,
  input  logic        cpu_sel,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        joy_irq,
  output logic [7:0]  joy_state
);

  localparam logic [DEBOUNCE_W-1:0] CNT_MAX = '1;
  localparam logic [DEBOUNCE_W-1:0] CNT_ONE = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};

  logic [7:0]            mapped;
  logic [7:0]            raw_q;
  logic [7:0]            stable;
  logic [7:0]            cleaned;
  logic [DEBOUNCE_W-1:0] cnt;
  logic [1:0]            sel;
  logic [3:0]            dir;
  logic [3:0]            btn;
  logic [3:0]            low;
  logic [3:0]            low_q;
  logic                  diff;
  logic                  unused_buttons;

  // {Start, Select, B, A, Down, Up, Left, Right}, inverted to active-high
  assign mapped = ~{snes_buttons[3], snes_buttons[2], snes_buttons[0], snes_buttons[8],
                    snes_buttons[5], snes_buttons[4], snes_buttons[6], snes_buttons[7]};
  assign unused_buttons = ^{snes_buttons[15:9], snes_buttons[1]};

  assign diff = (mapped != raw_q);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      raw_q   <= 8'h00;
      cnt     <= '0;
      stable  <= 8'h00;
      sel     <= 2'b11;
      low_q   <= 4'hF;
      joy_irq <= 1'b0;
    end else begin
      raw_q <= mapped;
      if (diff)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_ONE;
      if ((cnt == CNT_MAX) && !diff)
        stable <= raw_q;
      if (cpu_sel && cpu_wr)
        sel <= cpu_wdata[5:4];
      low_q   <= low;
      joy_irq <= |(low_q & ~low);
    end
  end

  always_comb begin
    cleaned = stable;
`ifdef JOYPAD_SOCD_CLEAN_EN
    if (stable[3] && stable[2])
      cleaned[3:2] = 2'b00;
    if (stable[1] && stable[0])
      cleaned[1:0] = 2'b00;
`endif
  end

  assign joy_state = cleaned;
  assign dir       = cleaned[3:0];
  assign btn       = cleaned[7:4];

  // sel bits are active-low selects: P14 gates directions, P15 gates buttons
  assign low = ~((~{4{sel[0]}} & dir) | (~{4{sel[1]}} & btn));

  assign cpu_rdata = cpu_sel ? {2'b11, sel, low} : 8'hFF;

endmodule
